// File: rtl/cpu_mem_if.sv
// Data-memory bus between the MEM stage (master) and the memory slave.
// Latency: none, wires only.
// Backpressure: the slave holds bus_ready low until the access completes.
interface cpu_mem_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ready
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ready
    );
endinterface

// File: rtl/cpu_mem.sv
// MEM pipeline stage: byte/half/word loads and stores over a req/ready bus.
// Latency: 1 edge for non-memory ops; 2+ edges for aligned memory ops.
// Backpressure: mem_stall holds EX while a request waits for bus_ready.
`ifndef CPU_MEM_CON_DEFS
`define CPU_MEM_CON_DEFS
`define CON_MSB 15
`define CON_LSB 0
`define CON_NOP 16'h8000
`endif

module cpu_mem #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic [31:0]               current_pc_ex,
    input  logic [31:0]               ins_ex,
    input  logic [`CON_MSB:`CON_LSB]  controls_ex,
    input  logic [31:0]               alu_result,
    input  logic [31:0]               reg_read2_data_ex,
    input  logic                      reg_write_en,
    input  logic [4:0]                reg_write_num,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [1:0]                mem_size,
    input  logic                      mem_sext,
    cpu_mem_if.master                 bus,
    output logic                      mem_stall,
    output logic [31:0]               current_pc_mem,
    output logic [31:0]               ins_mem,
    output logic [`CON_MSB:`CON_LSB]  controls_mem,
    output logic [31:0]               reg_write_data,
    output logic                      reg_write_en_mem,
    output logic [4:0]                reg_write_num_mem,
    output logic                      align_error,
    output logic                      bus_error
);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    localparam logic [15:0]              CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [`CON_MSB:`CON_LSB] CON_NOP  = `CON_NOP;

    state_t                     state_q, state_d;
    logic                       bus_req_q, bus_req_d;
    logic                       bus_we_q, bus_we_d;
    logic [31:0]                bus_addr_q, bus_addr_d;
    logic [3:0]                 bus_be_q, bus_be_d;
    logic [31:0]                bus_wdata_q, bus_wdata_d;
    logic [15:0]                cnt_q, cnt_d;
    // Attributes of the outstanding access, needed to pick apart rdata.
    logic [1:0]                 lane_q, lane_d;
    logic [1:0]                 size_q, size_d;
    logic                       sext_q, sext_d;
    logic                       load_q, load_d;
    // MEM/WB latch
    logic [31:0]                pc_mem_q, pc_mem_d;
    logic [31:0]                ins_mem_q, ins_mem_d;
    logic [`CON_MSB:`CON_LSB]   ctrl_mem_q, ctrl_mem_d;
    logic [31:0]                wb_data_q, wb_data_d;
    logic                       wb_en_q, wb_en_d;
    logic [4:0]                 wb_num_q, wb_num_d;
    logic                       align_err_q, align_err_d;
    logic                       bus_err_q, bus_err_d;

    logic                       access;
    logic                       is_load;
    logic                       misaligned;
    logic                       timeout_hit;
    logic [3:0]                 be_c;
    logic [31:0]                wdata_c;
    logic [7:0]                 rd_byte;
    logic [15:0]                rd_half;
    logic [31:0]                load_val;

    // A simultaneous read+write is a store; it never writes a register.
    assign access      = mem_read | mem_write;
    assign is_load     = mem_read & ~mem_write;
    assign timeout_hit = (cnt_q == CNT_LAST);

    // Alignment check, lane enables and lane-replicated store data.
    always_comb begin
        misaligned = 1'b0;
        be_c       = 4'b1111;
        wdata_c    = reg_read2_data_ex;
        case (mem_size)
            2'd0: begin
                be_c    = 4'b0001 << alu_result[1:0];
                wdata_c = {4{reg_read2_data_ex[7:0]}};
            end
            2'd1: begin
                misaligned = access & alu_result[0];
                be_c       = alu_result[1] ? 4'b1100 : 4'b0011;
                wdata_c    = {2{reg_read2_data_ex[15:0]}};
            end
            default: begin
                misaligned = access & (alu_result[1:0] != 2'b00);
            end
        endcase
    end

    // Lane select and extension of returning load data.
    always_comb begin
        case (lane_q)
            2'd0:    rd_byte = bus.bus_rdata[7:0];
            2'd1:    rd_byte = bus.bus_rdata[15:8];
            2'd2:    rd_byte = bus.bus_rdata[23:16];
            default: rd_byte = bus.bus_rdata[31:24];
        endcase
        rd_half = lane_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (size_q)
            2'd0:    load_val = {{24{sext_q & rd_byte[7]}}, rd_byte};
            2'd1:    load_val = {{16{sext_q & rd_half[15]}}, rd_half};
            default: load_val = bus.bus_rdata;
        endcase
    end

    // Stall EX while an access is being issued or is still waiting.
    always_comb begin
        mem_stall = 1'b0;
        case (state_q)
            S_IDLE:  mem_stall = access & ~misaligned;
            S_WAIT:  mem_stall = ~bus.bus_ready & ~timeout_hit;
            default: mem_stall = 1'b0;
        endcase
    end

    // Next-state: MEM/WB defaults to a bubble; only completing ops override it.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        cnt_d       = cnt_q;
        lane_d      = lane_q;
        size_d      = size_q;
        sext_d      = sext_q;
        load_d      = load_q;
        align_err_d = align_err_q;
        bus_err_d   = bus_err_q;
        pc_mem_d    = 32'd0;
        ins_mem_d   = 32'd0;
        ctrl_mem_d  = CON_NOP;
        wb_data_d   = 32'd0;
        wb_en_d     = 1'b0;
        wb_num_d    = 5'd0;
        case (state_q)
            S_IDLE: begin
                if (access && misaligned) begin
                    align_err_d = 1'b1;
                end else if (access) begin
                    state_d     = S_WAIT;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_write;
                    bus_addr_d  = {alu_result[31:2], 2'b00};
                    bus_be_d    = be_c;
                    bus_wdata_d = wdata_c;
                    cnt_d       = 16'd0;
                    lane_d      = alu_result[1:0];
                    size_d      = mem_size;
                    sext_d      = mem_sext;
                    load_d      = is_load;
                end else begin
                    pc_mem_d   = current_pc_ex;
                    ins_mem_d  = ins_ex;
                    ctrl_mem_d = controls_ex;
                    wb_data_d  = alu_result;
                    wb_en_d    = reg_write_en;
                    wb_num_d   = reg_write_num;
                end
            end
            S_WAIT: begin
                if (bus.bus_ready) begin
                    state_d    = S_IDLE;
                    bus_req_d  = 1'b0;
                    pc_mem_d   = current_pc_ex;
                    ins_mem_d  = ins_ex;
                    ctrl_mem_d = controls_ex;
                    wb_data_d  = load_q ? load_val : alu_result;
                    wb_en_d    = load_q & reg_write_en;
                    wb_num_d   = reg_write_num;
                end else if (timeout_hit) begin
                    // Abandon the access; the instruction retires without writing.
                    state_d    = S_IDLE;
                    bus_req_d  = 1'b0;
                    bus_err_d  = 1'b1;
                    pc_mem_d   = current_pc_ex;
                    ins_mem_d  = ins_ex;
                    ctrl_mem_d = controls_ex;
                    wb_data_d  = alu_result;
                    wb_num_d   = reg_write_num;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; clr drops any outstanding request.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            cnt_q       <= 16'd0;
            lane_q      <= 2'd0;
            size_q      <= 2'd0;
            sext_q      <= 1'b0;
            load_q      <= 1'b0;
            pc_mem_q    <= 32'd0;
            ins_mem_q   <= 32'd0;
            ctrl_mem_q  <= CON_NOP;
            wb_data_q   <= 32'd0;
            wb_en_q     <= 1'b0;
            wb_num_q    <= 5'd0;
            align_err_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            cnt_q       <= cnt_d;
            lane_q      <= lane_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            load_q      <= load_d;
            pc_mem_q    <= pc_mem_d;
            ins_mem_q   <= ins_mem_d;
            ctrl_mem_q  <= ctrl_mem_d;
            wb_data_q   <= wb_data_d;
            wb_en_q     <= wb_en_d;
            wb_num_q    <= wb_num_d;
            align_err_q <= align_err_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus.bus_req        = bus_req_q;
    assign bus.bus_we         = bus_we_q;
    assign bus.bus_addr       = bus_addr_q;
    assign bus.bus_be         = bus_be_q;
    assign bus.bus_wdata      = bus_wdata_q;
    assign current_pc_mem     = pc_mem_q;
    assign ins_mem            = ins_mem_q;
    assign controls_mem       = ctrl_mem_q;
    assign reg_write_data     = wb_data_q;
    assign reg_write_en_mem   = wb_en_q;
    assign reg_write_num_mem  = wb_num_q;
    assign align_error        = align_err_q;
    assign bus_error          = bus_err_q;

endmodule
